// File: rtl/controlador_display_7_segmentos.sv
// 4-digit common-anode 7-seg scanner; define CONTROLADOR_DISPLAY_BLANK_CEROS_EN for leading-zero blanking.
// Latency: one cycle from the selected digit's data to o_Segmentos; anode and segments are registered together.
// Backpressure: none; data inputs are sampled every cycle, never latched.
module controlador_display_7_segmentos #(
    parameter int REFRESH_DIV = 4
) (
    input  logic       i_Reloj,
    input  logic       i_Reset,
    input  logic [3:0] i_Datos_0,
    input  logic [3:0] i_Datos_1,
    input  logic [3:0] i_Datos_2,
    input  logic [3:0] i_Datos_3,
    output logic [6:0] o_Segmentos,
    output logic [3:0] o_Anodo_4_Bits
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] prescaler;
    logic [1:0]    indice;
    logic [3:0]    dato_sel;
    logic          blanco;
    logic [6:0]    seg_sig;

    // Active-low gfedcba glyphs
    function automatic logic [6:0] decodificar(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        dato_sel = i_Datos_0;
        case (indice)
            2'd1:    dato_sel = i_Datos_1;
            2'd2:    dato_sel = i_Datos_2;
            2'd3:    dato_sel = i_Datos_3;
            default: dato_sel = i_Datos_0;
        endcase
    end

`ifdef CONTROLADOR_DISPLAY_BLANK_CEROS_EN
    // A digit is blank only when it and every more significant digit are zero; digit 0 always shows.
    always_comb begin
        blanco = 1'b0;
        case (indice)
            2'd3:    blanco = (i_Datos_3 == 4'h0);
            2'd2:    blanco = (i_Datos_3 == 4'h0) && (i_Datos_2 == 4'h0);
            2'd1:    blanco = (i_Datos_3 == 4'h0) && (i_Datos_2 == 4'h0) && (i_Datos_1 == 4'h0);
            default: blanco = 1'b0;
        endcase
    end
`else
    assign blanco = 1'b0;
`endif

    assign seg_sig = blanco ? 7'h7F : decodificar(dato_sel);

    always_ff @(posedge i_Reloj or negedge i_Reset) begin
        if (!i_Reset) begin
            prescaler      <= '0;
            indice         <= 2'd0;
            o_Anodo_4_Bits <= 4'b1111;
            o_Segmentos    <= 7'h7F;
        end else begin
            if (prescaler == PRESC_MAX) begin
                prescaler <= '0;
                indice    <= indice + 2'd1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
            // Outputs follow the pre-edge index so anode and glyph always match.
            o_Anodo_4_Bits <= ~(4'b0001 << indice);
            o_Segmentos    <= seg_sig;
        end
    end

endmodule

// File: tb/tb_controlador_display_7_segmentos.sv
// Directed bench for the 7-segment scanner: REFRESH_DIV=4 instance plus a REFRESH_DIV=1 instance.
module tb_controlador_display_7_segmentos;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rst1_n;
    logic [3:0] d0, d1, d2, d3;
    logic [6:0] seg, seg1;
    logic [3:0] an, an1;

    int checks = 0;
    int errors = 0;

    logic [6:0] tabla [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    always #5 clk = ~clk;

    controlador_display_7_segmentos #(.REFRESH_DIV(4)) dut (
        .i_Reloj(clk), .i_Reset(rst_n),
        .i_Datos_0(d0), .i_Datos_1(d1), .i_Datos_2(d2), .i_Datos_3(d3),
        .o_Segmentos(seg), .o_Anodo_4_Bits(an)
    );

    controlador_display_7_segmentos #(.REFRESH_DIV(1)) dut1 (
        .i_Reloj(clk), .i_Reset(rst1_n),
        .i_Datos_0(d0), .i_Datos_1(d1), .i_Datos_2(d2), .i_Datos_3(d3),
        .o_Segmentos(seg1), .o_Anodo_4_Bits(an1)
    );

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] esperado [4];
        rst_n  = 1'b0;
        rst1_n = 1'b0;
        d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;

        // Reset held for two cycles: all off, blank
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("rst_an_%0d", i), {3'b000, an}, 7'h0F);
            chk($sformatf("rst_seg_%0d", i), seg, 7'h7F);
        end
        chk("rst1_an", {3'b000, an1}, 7'h0F);

        // Scan 1,2,3,4 over 17 edges
        rst_n = 1'b1;
        for (int e = 1; e <= 17; e++) begin
            int k;
            k = ((e - 1) / 4) % 4;
            tick();
            chk($sformatf("scan_an_e%0d", e), {3'b000, an}, {3'b000, an_tab[k]});
            chk($sformatf("scan_seg_e%0d", e), seg, tabla[k + 1]);
        end

        // Sweep digit 0 through all 16 values, four per digit-0 window
        for (int v = 0; v < 16; v++) begin
            if (v % 4 == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            d0 = 4'(v);
            tick();
            chk($sformatf("sweep_seg_%0d", v), seg, tabla[v]);
            chk($sformatf("sweep_an_%0d", v), {3'b000, an}, 7'h0E);
        end

        // Reset asserted during digit 2
        d0 = 4'h1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (9) tick();
        chk("mid_an_d2", {3'b000, an}, 7'h0B);
        chk("mid_seg_d2", seg, 7'h30);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_an", {3'b000, an}, 7'h0F);
        chk("mid_rst_seg", seg, 7'h7F);
        tick();
        chk("mid_hold_an", {3'b000, an}, 7'h0F);
        rst_n = 1'b1;
        tick();
        chk("mid_restart_an", {3'b000, an}, 7'h0E);
        chk("mid_restart_seg", seg, 7'h79);

        // REFRESH_DIV=1 rotates every edge
        rst1_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("div1_an_%0d", i), {3'b000, an1}, {3'b000, an_tab[i % 4]});
            chk($sformatf("div1_seg_%0d", i), seg1, tabla[(i % 4) + 1]);
        end

        // Digits 3..0 = 0,0,5,0
        d3 = 4'h0; d2 = 4'h0; d1 = 4'h5; d0 = 4'h0;
`ifdef CONTROLADOR_DISPLAY_BLANK_CEROS_EN
        esperado = '{7'h40, 7'h12, 7'h7F, 7'h7F};
`else
        esperado = '{7'h40, 7'h12, 7'h40, 7'h40};
`endif
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            int k;
            k = (e - 1) / 4;
            tick();
            chk($sformatf("zero_an_e%0d", e), {3'b000, an}, {3'b000, an_tab[k]});
            chk($sformatf("zero_seg_e%0d", e), seg, esperado[k]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
